adder_share_arbiter: RTL and testbench

Arbitrates and sequences one shared 28-bit ripple-carry final-stage adder between two requesters. Each requester presents an operand pair (28-bit `a`, 27-bit `b`) with a valid/ready handshake. The arbiter grants one requester, latches its operands and holds them stable for a configurable number of settling cycles. It then registers the sum and returns it on that requester's response channel. It sits between the multiplier partial-product stages and the final carry-propagate adder, so two product streams can share one adder.

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/rca_last_stage.sv | 22 ++
 rtl/adder_share_arbiter.sv | 128 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and widths for the adder share arbiter
package adder_arb_pkg;
    localparam int SUM_W   = 28;
    localparam int B_W     = 27;
    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/rca_last_stage.sv
// rtl/rca_last_stage.sv - 28-bit ripple-carry final-stage adder, b zero-extended, carry out dropped
module rca_last_stage
    import adder_arb_pkg::*;
(
    input  logic [SUM_W-1:0] i_a,
    input  logic [B_W-1:0]   i_b,
    output logic [SUM_W-1:0] o_sum
);
    logic [SUM_W-1:0] w_b_ext;
    logic             w_carry;

    assign w_b_ext = {{(SUM_W-B_W){1'b0}}, i_b};

    always_comb begin
        o_sum   = '0;
        w_carry = 1'b0;
        for (int i = 0; i < SUM_W; i++) begin
            o_sum[i] = i_a[i] ^ w_b_ext[i] ^ w_carry;
            w_carry  = (i_a[i] & w_b_ext[i]) | (w_carry & (i_a[i] ^ w_b_ext[i]));
        end
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - two-requester arbiter sharing one final-stage adder
// ADDER_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 first) instead of round-robin.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int CALC_CYCLES = 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [SUM_W-1:0]   req_a0,
    input  logic [SUM_W-1:0]   req_a1,
    input  logic [B_W-1:0]     req_b0,
    input  logic [B_W-1:0]     req_b1,
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [SUM_W-1:0]   rsp_sum,
    output logic               busy
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CALC_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic [SUM_W-1:0]   r_a;
    logic [B_W-1:0]     r_b;
    logic [SUM_W-1:0]   r_rsp_sum;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [SUM_W-1:0]   w_sum;
    logic               w_win;
    logic               w_accept;
    logic               w_rsp_done;

    assign w_accept   = (r_state == ST_IDLE) && (|req_valid);
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready[r_id];

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign w_win = ~req_valid[0];
`else
    logic r_ptr;

    // Pointer only matters on a tie; a lone requester always wins.
    assign w_win = (&req_valid) ? r_ptr : req_valid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_rsp_done) begin
            r_ptr <= ~r_id;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)      w_state_nxt = ST_CALC;
            ST_CALC: if (r_cnt == '0)   w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_done)    w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // req_ready is gated by rst_n so it reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (w_accept && rst_n) begin
            req_ready[w_win] = 1'b1;
        end
        busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_sum   <= '0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id  <= w_win;
                        r_a   <= w_win ? req_a1 : req_a0;
                        r_b   <= w_win ? req_b1 : req_b0;
                        r_cnt <= CNT_INIT;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0) begin
                        r_rsp_sum   <= w_sum;
                        r_rsp_valid <= NUM_REQ'(1) << r_id;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_rsp_valid <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;

    rca_last_stage u_rca (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_sum)
    );
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;
    localparam int CC  = 1;
    localparam int CC4 = 4;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  rsp_ready = '0;
    logic [27:0] req_a0 = '0, req_a1 = '0;
    logic [26:0] req_b0 = '0, req_b1 = '0;
    logic [1:0]  req_ready, rsp_valid, req_ready4, rsp_valid4;
    logic [27:0] rsp_sum, rsp_sum4;
    logic        busy, busy4;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(.CALC_CYCLES(CC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .busy(busy)
    );

    adder_share_arbiter #(.CALC_CYCLES(CC4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] ref_sum(input logic [27:0] a, input logic [26:0] b);
        logic [28:0] full;
        full = {1'b0, a} + {2'b00, b};
        return full[27:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single(input int r, input logic [27:0] a, input logic [26:0] b,
                          input logic [27:0] exp, input string tag);
        @(posedge clk); #1;
        if (r == 0) begin req_a0 = a; req_b0 = b; end
        else        begin req_a1 = a; req_b1 = b; end
        req_valid = 2'b01 << r;
        rsp_ready = 2'b11;
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 2'b01 << r);
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < CC; k++) begin
            @(negedge clk);
            check({tag, "_early"}, rsp_valid, 0);
            check({tag, "_busy"}, busy, 1);
        end
        @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 2'b01 << r);
        check({tag, "_sum"}, rsp_sum, exp);
        @(negedge clk);
        check({tag, "_done"}, rsp_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        logic [1:0]  rr_v[3];
        logic [27:0] rr_s[3];
        int          got;
        logic [1:0]  pend;
        logic [27:0] op_a[2];
        logic [26:0] op_b[2];
        bit          out_q;
        bit          ptr;
        int          e, due, id, w;
        logic [27:0] exp_sum;

        #12;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_busy", busy, 0);
        check("rst_busy4", busy4, 0);
        @(negedge clk);
        rst_n = 1'b1;

        single(0, 28'h0FFFFFF, 27'h0000001, 28'h1000000, "basic");
        single(0, 28'hFFFFFFF, 27'h0000001, 28'h0000000, "wrap");

        // Operands latched at accept; later input changes must not leak into the sum.
        do_reset();
        @(posedge clk); #1;
        req_a0 = 28'h1234567; req_b0 = 27'h0ABCDEF;
        req_valid = 2'b01; rsp_ready = 2'b00;
        @(negedge clk);
        check("lat_ready", req_ready4, 2'b01);
        @(posedge clk); #1;
        req_a0 = 28'hFFFFFFF; req_b0 = 27'h7FFFFFF; req_valid = '0;
        for (int k = 0; k < CC4; k++) begin
            @(negedge clk);
            check("lat_early", rsp_valid4, 0);
        end
        @(negedge clk);
        check("lat_valid", rsp_valid4, 2'b01);
        check("lat_sum", rsp_sum4, 28'h1CF1356);
        rsp_ready = 2'b11;
        @(negedge clk);
        check("lat_done", rsp_valid4, 0);

        // Reset in the middle of CALC on the 4-cycle instance.
        @(posedge clk); #1;
        req_a0 = 28'd100; req_b0 = 27'd23; req_a1 = 28'd1; req_b1 = 27'd2;
        req_valid = 2'b11; rsp_ready = 2'b00;
        @(negedge clk);
        check("mid_grant", req_ready4, FIXED ? 2'b01 : 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy4, 0);
        check("mid_valid", rsp_valid4, 0);
        check("mid_sum", rsp_sum4, 0);
        check("mid_ready", req_ready4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_reaccept", req_ready4, 2'b01);
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (CC4) @(negedge clk);
        @(negedge clk);
        check("mid_rsp_valid", rsp_valid4, 2'b01);
        check("mid_rsp_sum", rsp_sum4, 28'd123);

        // Both requesters valid continuously.
        if (FIXED) begin
            rr_v = '{2'b01, 2'b01, 2'b01}; rr_s = '{28'd8, 28'd8, 28'd8};
        end else begin
            rr_v = '{2'b01, 2'b10, 2'b01}; rr_s = '{28'd8, 28'd17, 28'd8};
        end
        do_reset();
        @(posedge clk); #1;
        req_a0 = 28'd5; req_b0 = 27'd3; req_a1 = 28'd10; req_b1 = 27'd7;
        req_valid = 2'b11; rsp_ready = 2'b11;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            if (rsp_valid != 0) begin
                check("rr_id", rsp_valid, rr_v[got]);
                check("rr_sum", rsp_sum, rr_s[got]);
                got++;
            end
        end
        check("rr_count", got, 3);

        // Backpressure; requester 0's rsp_ready must be ignored while 1 is served.
        do_reset();
        @(posedge clk); #1;
        req_a1 = 28'hABCDEF0; req_b1 = 27'h7FFFFFF; req_valid = 2'b10; rsp_ready = 2'b01;
        @(posedge clk); #1;
        req_a0 = 28'd42; req_b0 = 27'd8; req_valid = 2'b01;
        repeat (CC) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 2'b10);
            check("bp_sum", rsp_sum, 28'h2BCDEEF);
            check("bp_busy", busy, 1);
            check("bp_noready", req_ready, 0);
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("bp_done", rsp_valid, 0);
        check("bp_idle", busy, 0);
        check("bp_next_ready", req_ready, 2'b01);
        @(negedge clk);
        check("bp_next_busy", busy, 1);
        req_valid = '0;
        repeat (CC + 2) @(negedge clk);

        // Randomized traffic against a transaction-level model.
        do_reset();
        pend = '0; out_q = 0; ptr = 0; e = 0; due = 0; id = 0; exp_sum = '0;
        op_a = '{28'd0, 28'd0}; op_b = '{27'd0, 27'd0};
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); e++; #1;
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && $urandom_range(15) == 0) begin
                    pend[r] = 1'b0;
                end else if (!pend[r] && $urandom_range(2) == 0) begin
                    pend[r] = 1'b1;
                    op_a[r] = 28'($urandom);
                    op_b[r] = 27'($urandom);
                end
            end
            req_valid = pend;
            req_a0 = op_a[0]; req_b0 = op_b[0];
            req_a1 = op_a[1]; req_b1 = op_b[1];
            rsp_ready = 2'($urandom_range(3));
            @(negedge clk);
            if (out_q) begin
                check("rnd_ready_busy", req_ready, 0);
                check("rnd_busy", busy, 1);
                if (e >= due) begin
                    check("rnd_valid", rsp_valid, 2'b01 << id);
                    check("rnd_sum", rsp_sum, exp_sum);
                    if (rsp_ready[id]) begin
                        out_q = 0;
                        ptr = (id == 0);
                    end
                end else begin
                    check("rnd_early", rsp_valid, 0);
                end
            end else begin
                check("rnd_idle_valid", rsp_valid, 0);
                check("rnd_idle_busy", busy, 0);
                if (pend != 2'b00) begin
                    w = (pend == 2'b11) ? (FIXED ? 0 : int'(ptr)) : ((pend == 2'b10) ? 1 : 0);
                    check("rnd_grant", req_ready, 2'b01 << w);
                    out_q = 1; id = w; due = e + 1 + CC;
                    exp_sum = ref_sum(op_a[w], op_b[w]);
                    pend[w] = 1'b0;
                end else begin
                    check("rnd_idle_ready", req_ready, 0);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
